// File: rtl/qpsk_div_pkg.sv
// Shared types and constants for the QPSK sequential unsigned divider.
package qpsk_div_pkg;

    localparam int DIV_DIVIDEND_W = 30;
    localparam int DIV_DIVISOR_W  = 15;

    localparam logic [DIV_DIVISOR_W-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_e;

endpackage

// File: rtl/qpsk_hls_top_div_seq_30u_15u_if.sv
// Operand/result handshake bundle between the divider and its producer/consumer.
interface qpsk_hls_top_div_seq_30u_15u_if
    import qpsk_div_pkg::*;
#(
    parameter int DIVIDEND_W = DIV_DIVIDEND_W,
    parameter int DIVISOR_W  = DIV_DIVISOR_W
);

    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIVISOR_W-1:0]  quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;
    logic                  overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

endinterface

// File: rtl/qpsk_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
module qpsk_div_step #(
    parameter int W = 15
) (
    input  logic [W-1:0] rem,
    input  logic         nxt_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_nxt,
    output logic         q_bit
);

    logic [W:0] trial;

    assign trial = {rem, nxt_bit};
    assign q_bit = (trial >= {1'b0, divisor});
    // The difference is below divisor, so W-bit modular subtraction is exact.
    assign rem_nxt = q_bit ? (trial[W-1:0] - divisor) : trial[W-1:0];

endmodule

// File: rtl/qpsk_hls_top_div_seq_30u_15u.sv
// Sequential 30u/15u restoring divider, one quotient bit per enabled cycle.
module qpsk_hls_top_div_seq_30u_15u
    import qpsk_div_pkg::*;
#(
    parameter int DIVIDEND_W = DIV_DIVIDEND_W,
    parameter int DIVISOR_W  = DIV_DIVISOR_W,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    qpsk_hls_top_div_seq_30u_15u_if.slave bus
);

    div_state_e state, nxt_state;

    logic [CNT_W-1:0]     cnt;
    logic [DIVISOR_W-1:0] rem_r;
    logic [DIVISOR_W-1:0] sh_r;
    logic [DIVISOR_W-1:0] div_r;
    logic [DIVISOR_W-1:0] quot_r;
    logic [DIVISOR_W-1:0] rem_out_r;
    logic                 dbz_r;
    logic                 ovf_r;

    logic [DIVISOR_W-1:0] div_hi, div_lo;
    logic                 accept, op_dbz, op_ovf, last_step;
    logic [DIVISOR_W-1:0] step_rem;
    logic                 step_q;

    assign div_hi    = bus.dividend[DIVIDEND_W-1:DIVISOR_W];
    assign div_lo    = bus.dividend[DIVISOR_W-1:0];
    assign accept    = ce && bus.in_valid && (state == IDLE);
    assign op_dbz    = (bus.divisor == '0);
    // A high half at or above the divisor means the quotient needs more than DIVISOR_W bits.
    assign op_ovf    = !op_dbz && (div_hi >= bus.divisor);
    assign last_step = (cnt == CNT_W'(1));

    qpsk_div_step #(.W(DIVISOR_W)) u_step (
        .rem     (rem_r),
        .nxt_bit (sh_r[DIVISOR_W-1]),
        .divisor (div_r),
        .rem_nxt (step_rem),
        .q_bit   (step_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt_state;
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves nxt_state unassigned (no latch).
        nxt_state = state;
        unique case (state)
            IDLE: if (accept)                nxt_state = (op_dbz || op_ovf) ? DONE : BUSY;
            BUSY: if (ce && last_step)       nxt_state = DONE;
            DONE: if (ce && bus.out_ready)   nxt_state = IDLE;
            default:                         nxt_state = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    // Quotient bits enter the shift register LSB as dividend bits leave its MSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            rem_r     <= '0;
            sh_r      <= '0;
            div_r     <= '0;
            quot_r    <= '0;
            rem_out_r <= '0;
            dbz_r     <= 1'b0;
            ovf_r     <= 1'b0;
        end else if (ce) begin
            if (accept) begin
                if (op_dbz) begin
                    quot_r    <= ALL_ONES;
                    rem_out_r <= div_lo;
                    dbz_r     <= 1'b1;
                    ovf_r     <= 1'b0;
                end else if (op_ovf) begin
                    quot_r    <= ALL_ONES;
                    rem_out_r <= '0;
                    dbz_r     <= 1'b0;
                    ovf_r     <= 1'b1;
                end else begin
                    rem_r <= div_hi;
                    sh_r  <= div_lo;
                    div_r <= bus.divisor;
                    cnt   <= CNT_W'(DIVISOR_W);
                    dbz_r <= 1'b0;
                    ovf_r <= 1'b0;
                end
            end else if (state == BUSY) begin
                rem_r <= step_rem;
                sh_r  <= {sh_r[DIVISOR_W-2:0], step_q};
                cnt   <= cnt - CNT_W'(1);
                if (last_step) begin
                    quot_r    <= {sh_r[DIVISOR_W-2:0], step_q};
                    rem_out_r <= step_rem;
                end
            end
        end
    end

    assign bus.quotient    = quot_r;
    assign bus.remainder   = rem_out_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.overflow    = ovf_r;

endmodule

// File: tb/tb_qpsk_hls_top_div_seq_30u_15u.sv
// Randomized and directed bench for the sequential divider against an arithmetic reference.
module tb_qpsk_hls_top_div_seq_30u_15u;

    logic clk = 1'b0;
    logic reset;
    logic ce;

    qpsk_hls_top_div_seq_30u_15u_if bus ();

    qpsk_hls_top_div_seq_30u_15u dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference: plain integer division plus the error-flag rules.
    task automatic model(input int unsigned dd, input int unsigned dv,
                         output int unsigned q, output int unsigned r,
                         output bit z, output bit o, output int lat);
        z = 0; o = 0;
        if (dv == 0) begin
            q = 32767; r = dd % 32768; z = 1; lat = 0;
        end else if (dd / dv > 32767) begin
            q = 32767; r = 0; o = 1; lat = 0;
        end else begin
            q = dd / dv; r = dd % dv; lat = 15;
        end
    endtask

    task automatic run_op(input string name, input int unsigned dd, input int unsigned dv,
                          input int gap_at, input int gap_len, input int hold);
        int unsigned q, r;
        bit z, o;
        int exp_lat, lat;
        model(dd, dv, q, r, z, o, exp_lat);
        @(negedge clk);
        check({name, ".in_ready"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.dividend = 30'(dd);
        bus.divisor  = 15'(dv);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            if (gap_len > 0 && lat == gap_at) ce = 1'b0;
            if (gap_len > 0 && lat == gap_at + gap_len) ce = 1'b1;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        ce = 1'b1;
        check({name, ".latency"}, lat, exp_lat + gap_len);
        check({name, ".quotient"}, bus.quotient, q);
        check({name, ".remainder"}, bus.remainder, r);
        check({name, ".flags"}, {bus.div_by_zero, bus.overflow}, {z, o});
        check({name, ".busy_ready"}, bus.in_ready, 0);
        if (hold > 0) begin
            bus.in_valid = 1'b1;
            bus.dividend = 30'd12345;
            bus.divisor  = 15'd3;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                @(negedge clk);
            end
            check({name, ".hold_valid"}, bus.out_valid, 1);
            check({name, ".hold_q"}, bus.quotient, q);
            check({name, ".hold_r"}, bus.remainder, r);
            check({name, ".hold_ready"}, bus.in_ready, 0);
            bus.in_valid = 1'b0;
            ce = 1'b0;
            bus.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check({name, ".ce_hold"}, bus.out_valid, 1);
            ce = 1'b1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({name, ".released"}, {bus.out_valid, bus.in_ready}, 2'b01);
    endtask

    initial begin
        int unsigned dv, dd, qq, rr;
        int sel;
        reset = 1'b1;
        ce = 1'b1;
        bus.in_valid = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.ready_valid", {bus.in_ready, bus.out_valid}, 2'b10);
        check("reset.outputs", {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}, 0);
        reset = 1'b0;

        run_op("prod", 83810205, 6789, 0, 0, 0);
        run_op("d100_7", 100, 7, 0, 0, 0);
        run_op("max", 1073709055, 32767, 0, 0, 0);
        run_op("ovf", 163840, 5, 0, 0, 0);
        run_op("dbz", 32'h3FFF_1234, 0, 0, 0, 0);
        run_op("backpressure", 100, 7, 0, 0, 10);
        run_op("ce_gap", 83810205, 6789, 4, 5, 0);

        // Abort mid-division with reset, then confirm a clean restart.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.dividend = 30'd83810205;
        bus.divisor  = 15'd6789;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort.ready_valid", {bus.in_ready, bus.out_valid}, 2'b10);
        check("abort.outputs", {bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow}, 0);
        run_op("after_abort", 100, 7, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            sel = int'($urandom_range(0, 9));
            dv = (sel == 0) ? 0 : $urandom_range(1, 32767);
            if (sel <= 1) begin
                dd = $urandom & 32'h3FFF_FFFF;
            end else begin
                qq = $urandom_range(0, 32767);
                rr = $urandom_range(0, dv - 1);
                dd = qq * dv + rr;
            end
            run_op($sformatf("rand%0d", i), dd, dv, 0, 0, (i % 4 == 3) ? 2 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
